// File: rtl/hwpe_stream_sink_tcdm_if.sv
// HWPE stream handshake bundle: valid/ready flow control with data and byte strobes.
interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;

    modport source (output valid, output data, output strb, input ready);
    modport sink   (input valid, input data, input strb, output ready);
endinterface

// File: rtl/hwpe_stream_sink_tcdm.sv
// Drains an HWPE stream into TCDM as strided word writes, one write per stream beat,
// with busy/done reporting towards the engine controller.
module hwpe_stream_sink_tcdm #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [ADDR_WIDTH-1:0]   stride_i,
    input  logic [CNT_WIDTH-1:0]    length_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CNT_WIDTH-1:0]    beat_cnt_o,
    hwpe_stream_intf_stream.sink    stream_i,
    output logic                    tcdm_req_o,
    input  logic                    tcdm_gnt_i,
    output logic [ADDR_WIDTH-1:0]   tcdm_add_o,
    output logic                    tcdm_wen_o,
    output logic [DATA_WIDTH/8-1:0] tcdm_be_o,
    output logic [DATA_WIDTH-1:0]   tcdm_data_o
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH-1:0] stride_reg, stride_next;
    logic [CNT_WIDTH-1:0]  length_reg, length_next;
    logic [CNT_WIDTH-1:0]  cnt_reg, cnt_next;
    logic                  beat_done;
    logic                  last_beat;

    // In RUN length_reg is at least 1, so length-1 never underflows here.
    assign beat_done = (state_reg == RUN) & stream_i.valid & tcdm_gnt_i;
    assign last_beat = (cnt_reg == (length_reg - CNT_WIDTH'(1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = (length_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (beat_done && last_beat) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear_i) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        busy_o     = (state_reg == RUN);
        done_o     = (state_reg == DONE);
        tcdm_req_o = (state_reg == RUN) & stream_i.valid;
        tcdm_wen_o = 1'b0;
        tcdm_add_o = tcdm_req_o ? addr_reg : '0;
    end

    assign stream_i.ready = beat_done;
    assign beat_cnt_o     = cnt_reg;

    // Data and byte enables are forced to zero whenever no request is on the bus.
    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_byte_lane
            assign tcdm_data_o[gi*8 +: 8] = stream_i.data[gi*8 +: 8] & {8{tcdm_req_o}};
            assign tcdm_be_o[gi]          = stream_i.strb[gi] & tcdm_req_o;
        end
    endgenerate

    always_comb begin
        addr_next   = addr_reg;
        stride_next = stride_reg;
        length_next = length_reg;
        cnt_next    = cnt_reg;
        if ((state_reg == IDLE) && start_i) begin
            addr_next   = base_addr_i;
            stride_next = stride_i;
            length_next = length_i;
            cnt_next    = '0;
        end else if (beat_done) begin
            addr_next = addr_reg + stride_reg;
            cnt_next  = cnt_reg + CNT_WIDTH'(1);
        end
        if (clear_i) begin
            addr_next   = '0;
            stride_next = '0;
            length_next = '0;
            cnt_next    = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_reg   <= '0;
            stride_reg <= '0;
            length_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            addr_reg   <= addr_next;
            stride_reg <= stride_next;
            length_reg <= length_next;
            cnt_reg    <= cnt_next;
        end
    end

endmodule

// File: tb/tb_hwpe_stream_sink_tcdm.sv
// Directed bench for the stream-to-TCDM sink: strided addressing, grant stalls, wrap, zero length,
// ignored starts and mid-transfer clear.
module tb_hwpe_stream_sink_tcdm;
    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        clear_i = 1'b0;
    logic        start_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [31:0] stride_i = '0;
    logic [15:0] length_i = '0;
    logic        busy_o, done_o;
    logic [15:0] beat_cnt_o;
    logic        tcdm_req_o;
    logic        tcdm_gnt_i = 1'b0;
    logic [31:0] tcdm_add_o;
    logic        tcdm_wen_o;
    logic [3:0]  tcdm_be_o;
    logic [31:0] tcdm_data_o;

    int n_vec = 0;
    int n_err = 0;

    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) stream ();

    hwpe_stream_sink_tcdm #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .CNT_WIDTH (16)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .start_i    (start_i),
        .base_addr_i(base_addr_i),
        .stride_i   (stride_i),
        .length_i   (length_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .beat_cnt_o (beat_cnt_o),
        .stream_i   (stream),
        .tcdm_req_o (tcdm_req_o),
        .tcdm_gnt_i (tcdm_gnt_i),
        .tcdm_add_o (tcdm_add_o),
        .tcdm_wen_o (tcdm_wen_o),
        .tcdm_be_o  (tcdm_be_o),
        .tcdm_data_o(tcdm_data_o)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] len);
        start_i     = 1'b1;
        base_addr_i = base;
        stride_i    = stride;
        length_i    = len;
        next_cycle();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        stream.valid = 1'b1;
        stream.data  = 32'hDEADBEEF;
        stream.strb  = 4'hF;
        tcdm_gnt_i   = 1'b1;
        start_i      = 1'b1;
        length_i     = 16'd4;
        @(negedge clk);
        n_vec++; if ({busy_o, done_o, tcdm_req_o, stream.ready} !== 4'b0000) begin
            n_err++; $display("FAIL reset_ctrl: busy/done/req/ready=%b expected 0000", {busy_o, done_o, tcdm_req_o, stream.ready});
        end
        n_vec++; if (tcdm_add_o !== 32'h0) begin
            n_err++; $display("FAIL reset_addr: got %h expected 00000000", tcdm_add_o);
        end
        n_vec++; if (beat_cnt_o !== 16'd0) begin
            n_err++; $display("FAIL reset_cnt: got %0d expected 0", beat_cnt_o);
        end
        n_vec++; if (tcdm_wen_o !== 1'b0) begin
            n_err++; $display("FAIL reset_wen: got %b expected 0", tcdm_wen_o);
        end
        start_i      = 1'b0;
        stream.valid = 1'b0;
        tcdm_gnt_i   = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        next_cycle();
        $display("reset released");
    endtask

    task automatic test_basic();
        stream.valid = 1'b1;
        stream.strb  = 4'hF;
        tcdm_gnt_i   = 1'b1;
        start_i      = 1'b1;
        base_addr_i  = 32'h1000;
        stride_i     = 32'd4;
        length_i     = 16'd4;
        @(negedge clk);
        n_vec++; if (tcdm_req_o !== 1'b0 || stream.ready !== 1'b0) begin
            n_err++; $display("FAIL basic_idle_req: req=%b ready=%b expected 0 0", tcdm_req_o, stream.ready);
        end
        next_cycle();
        start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            stream.data = 32'hA0A0_0000 + i;
            @(negedge clk);
            $display("basic beat %0d: req=%b addr=%h data=%h", i, tcdm_req_o, tcdm_add_o, tcdm_data_o);
            n_vec++; if (tcdm_add_o !== 32'h1000 + 32'(4 * i)) begin
                n_err++; $display("FAIL basic_addr beat %0d: got %h expected %h", i, tcdm_add_o, 32'h1000 + 32'(4 * i));
            end
            n_vec++; if (tcdm_data_o !== 32'hA0A0_0000 + i || tcdm_be_o !== 4'hF) begin
                n_err++; $display("FAIL basic_data beat %0d: got %h/%h expected %h/f", i, tcdm_data_o, tcdm_be_o, 32'hA0A0_0000 + i);
            end
            n_vec++; if ({tcdm_req_o, stream.ready, busy_o, done_o} !== 4'b1110) begin
                n_err++; $display("FAIL basic_ctrl beat %0d: req/ready/busy/done=%b expected 1110", i, {tcdm_req_o, stream.ready, busy_o, done_o});
            end
            n_vec++; if (beat_cnt_o !== 16'(i)) begin
                n_err++; $display("FAIL basic_cnt beat %0d: got %0d expected %0d", i, beat_cnt_o, i);
            end
            next_cycle();
        end
        @(negedge clk);
        n_vec++; if ({tcdm_req_o, stream.ready, busy_o, done_o} !== 4'b0001) begin
            n_err++; $display("FAIL basic_done: req/ready/busy/done=%b expected 0001", {tcdm_req_o, stream.ready, busy_o, done_o});
        end
        n_vec++; if (beat_cnt_o !== 16'd4) begin
            n_err++; $display("FAIL basic_final_cnt: got %0d expected 4", beat_cnt_o);
        end
        next_cycle();
        @(negedge clk);
        n_vec++; if (done_o !== 1'b0 || tcdm_req_o !== 1'b0 || beat_cnt_o !== 16'd4) begin
            n_err++; $display("FAIL basic_idle_after: done=%b req=%b cnt=%0d expected 0 0 4", done_o, tcdm_req_o, beat_cnt_o);
        end
        stream.valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_gnt_stall();
        int b;
        int writes;
        b      = 0;
        writes = 0;
        kick(32'h1000, 32'd4, 16'd4);
        stream.valid = 1'b0;
        stream.data  = 32'h5555AAAA;
        stream.strb  = 4'hF;
        tcdm_gnt_i   = 1'b1;
        @(negedge clk);
        n_vec++; if (tcdm_req_o !== 1'b0 || stream.ready !== 1'b0 || tcdm_data_o !== 32'h0 || tcdm_be_o !== 4'h0) begin
            n_err++; $display("FAIL stall_novalid: req=%b ready=%b data=%h be=%h expected 0 0 0 0", tcdm_req_o, stream.ready, tcdm_data_o, tcdm_be_o);
        end
        next_cycle();
        for (int k = 0; k < 16 && b < 4; k++) begin
            stream.valid = 1'b1;
            stream.data  = 32'hB000_0000 + b;
            stream.strb  = 4'h3;
            tcdm_gnt_i   = (k % 2 == 1);
            @(negedge clk);
            $display("stall cycle %0d: gnt=%b addr=%h data=%h ready=%b", k, tcdm_gnt_i, tcdm_add_o, tcdm_data_o, stream.ready);
            n_vec++; if (tcdm_req_o !== 1'b1 || tcdm_add_o !== 32'h1000 + 32'(4 * b) || tcdm_data_o !== 32'hB000_0000 + b || tcdm_be_o !== 4'h3) begin
                n_err++; $display("FAIL stall_hold cycle %0d: req=%b addr=%h data=%h be=%h expected 1 %h %h 3",
                                  k, tcdm_req_o, tcdm_add_o, tcdm_data_o, tcdm_be_o, 32'h1000 + 32'(4 * b), 32'hB000_0000 + b);
            end
            n_vec++; if (stream.ready !== tcdm_gnt_i || beat_cnt_o !== 16'(b)) begin
                n_err++; $display("FAIL stall_ready cycle %0d: ready=%b cnt=%0d expected %b %0d", k, stream.ready, beat_cnt_o, tcdm_gnt_i, b);
            end
            if (stream.ready === 1'b1) writes++;
            if (tcdm_gnt_i) b++;
            next_cycle();
        end
        n_vec++; if (b != 4 || writes != 4) begin
            n_err++; $display("FAIL stall_writes: beats=%0d writes=%0d expected 4 4", b, writes);
        end
        @(negedge clk);
        n_vec++; if (done_o !== 1'b1 || tcdm_req_o !== 1'b0 || beat_cnt_o !== 16'd4) begin
            n_err++; $display("FAIL stall_done: done=%b req=%b cnt=%0d expected 1 0 4", done_o, tcdm_req_o, beat_cnt_o);
        end
        stream.valid = 1'b0;
        tcdm_gnt_i   = 1'b1;
        next_cycle();
    endtask

    task automatic test_stride_wrap();
        logic [31:0] exp_a [5];
        exp_a[0] = 32'h2000;
        exp_a[1] = 32'h1FFC;
        exp_a[2] = 32'h1FF8;
        exp_a[3] = 32'hFFFFFFFC;
        exp_a[4] = 32'h00000004;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) kick(32'h2000, 32'hFFFFFFFC, 16'd3);
            else        kick(32'hFFFFFFFC, 32'd8, 16'd2);
            for (int i = 0; i < 3 - t; i++) begin
                stream.valid = 1'b1;
                stream.data  = 32'hC0 + i;
                stream.strb  = 4'hF;
                tcdm_gnt_i   = 1'b1;
                @(negedge clk);
                $display("stride run %0d beat %0d: addr=%h", t, i, tcdm_add_o);
                n_vec++; if (tcdm_add_o !== exp_a[3 * t + i]) begin
                    n_err++; $display("FAIL stride_addr run %0d beat %0d: got %h expected %h", t, i, tcdm_add_o, exp_a[3 * t + i]);
                end
                next_cycle();
            end
            @(negedge clk);
            n_vec++; if (done_o !== 1'b1 || beat_cnt_o !== 16'(3 - t)) begin
                n_err++; $display("FAIL stride_done run %0d: done=%b cnt=%0d expected 1 %0d", t, done_o, beat_cnt_o, 3 - t);
            end
            stream.valid = 1'b0;
            next_cycle();
        end
    endtask

    task automatic test_zero_len();
        stream.valid = 1'b1;
        stream.data  = 32'h12345678;
        tcdm_gnt_i   = 1'b1;
        kick(32'h6000, 32'd4, 16'd0);
        @(negedge clk);
        $display("zero length: done=%b req=%b cnt=%0d", done_o, tcdm_req_o, beat_cnt_o);
        n_vec++; if (done_o !== 1'b1 || tcdm_req_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL zero_done: done=%b req=%b busy=%b expected 1 0 0", done_o, tcdm_req_o, busy_o);
        end
        n_vec++; if (beat_cnt_o !== 16'd0) begin
            n_err++; $display("FAIL zero_cnt: got %0d expected 0", beat_cnt_o);
        end
        next_cycle();
        @(negedge clk);
        n_vec++; if (done_o !== 1'b0 || tcdm_req_o !== 1'b0) begin
            n_err++; $display("FAIL zero_after: done=%b req=%b expected 0 0", done_o, tcdm_req_o);
        end
        stream.valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_restart_ignored();
        kick(32'h3000, 32'd4, 16'd3);
        for (int i = 0; i < 3; i++) begin
            stream.valid = 1'b1;
            stream.data  = 32'hD0 + i;
            tcdm_gnt_i   = 1'b1;
            start_i      = (i == 1);
            base_addr_i  = 32'h9000;
            length_i     = 16'd1;
            @(negedge clk);
            $display("restart beat %0d: addr=%h", i, tcdm_add_o);
            n_vec++; if (tcdm_add_o !== 32'h3000 + 32'(4 * i) || tcdm_req_o !== 1'b1) begin
                n_err++; $display("FAIL restart_addr beat %0d: got %h req=%b expected %h 1", i, tcdm_add_o, tcdm_req_o, 32'h3000 + 32'(4 * i));
            end
            next_cycle();
        end
        start_i = 1'b1;
        @(negedge clk);
        n_vec++; if (done_o !== 1'b1 || beat_cnt_o !== 16'd3) begin
            n_err++; $display("FAIL restart_done: done=%b cnt=%0d expected 1 3", done_o, beat_cnt_o);
        end
        next_cycle();
        start_i = 1'b0;
        @(negedge clk);
        n_vec++; if (busy_o !== 1'b0 || tcdm_req_o !== 1'b0) begin
            n_err++; $display("FAIL restart_in_done: busy=%b req=%b expected 0 0", busy_o, tcdm_req_o);
        end
        stream.valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_clear();
        kick(32'h4000, 32'd4, 16'd5);
        for (int i = 0; i < 2; i++) begin
            stream.valid = 1'b1;
            stream.data  = 32'hE0 + i;
            tcdm_gnt_i   = 1'b1;
            next_cycle();
        end
        tcdm_gnt_i = 1'b0;
        clear_i    = 1'b1;
        @(negedge clk);
        n_vec++; if (tcdm_req_o !== 1'b1 || tcdm_add_o !== 32'h4008) begin
            n_err++; $display("FAIL clear_inflight: req=%b addr=%h expected 1 00004008", tcdm_req_o, tcdm_add_o);
        end
        next_cycle();
        clear_i    = 1'b0;
        tcdm_gnt_i = 1'b1;
        @(negedge clk);
        $display("after clear: busy=%b req=%b done=%b cnt=%0d", busy_o, tcdm_req_o, done_o, beat_cnt_o);
        n_vec++; if ({busy_o, tcdm_req_o, done_o} !== 3'b000 || beat_cnt_o !== 16'd0) begin
            n_err++; $display("FAIL clear_idle: busy/req/done=%b cnt=%0d expected 000 0", {busy_o, tcdm_req_o, done_o}, beat_cnt_o);
        end
        next_cycle();
        @(negedge clk);
        n_vec++; if (done_o !== 1'b0) begin
            n_err++; $display("FAIL clear_nodone: done=%b expected 0", done_o);
        end
        stream.valid = 1'b0;
        next_cycle();
        kick(32'h5000, 32'd4, 16'd1);
        stream.valid = 1'b1;
        stream.data  = 32'hF00D;
        @(negedge clk);
        n_vec++; if (tcdm_req_o !== 1'b1 || tcdm_add_o !== 32'h5000 || stream.ready !== 1'b1 || tcdm_data_o !== 32'hF00D) begin
            n_err++; $display("FAIL clear_restart_beat: req=%b addr=%h ready=%b data=%h expected 1 00005000 1 0000f00d",
                              tcdm_req_o, tcdm_add_o, stream.ready, tcdm_data_o);
        end
        next_cycle();
        @(negedge clk);
        n_vec++; if (tcdm_req_o !== 1'b0 || done_o !== 1'b1 || beat_cnt_o !== 16'd1) begin
            n_err++; $display("FAIL clear_restart_done: req=%b done=%b cnt=%0d expected 0 1 1", tcdm_req_o, done_o, beat_cnt_o);
        end
        stream.valid = 1'b0;
        next_cycle();
    endtask

    initial begin
        stream.valid = 1'b0;
        stream.data  = '0;
        stream.strb  = '0;
        test_reset();
        test_basic();
        test_gnt_stall();
        test_stride_wrap();
        test_zero_len();
        test_restart_ignored();
        test_clear();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
